triangle_gen: RTL and testbench
===============================

Name: triangle_gen

Overview:
Parametrised successor of the APU triangle channel. It provides a wave generator with configurable timer, sample and linear-counter widths. New behaviour:
- separate quarter-frame (linear) and half-frame (length) strobes
- $4015 channel-enable gating and length status output
- sawtooth mode
- ultrasonic mute
It sits between the register file/frame sequencer and the mixer. One instance per wave voice.

Parameters:
TIMER_WIDTH, 11, width of period reload and timer down-counter
DATA_WIDTH, 4, sample width; sequencer has 2^(DATA_WIDTH+1) steps, MAX = 2^DATA_WIDTH-1
LINEAR_WIDTH, 7, width of linear counter and its preset
ULTRASONIC_MIN, 2, timer_preset values below this hold output at midpoint

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
enable_cpu  in  1  one-cycle timer tick strobe (1.79 MHz)
enable_quarter  in  1  quarter-frame strobe (~240 Hz), clocks linear counter
enable_half  in  1  half-frame strobe (~120 Hz), clocks length counter
channel_enable  in  1  $4015 channel bit; low forces length counter to 0
control  in  1  length-halt / linear-control flag ($4008 bit 7)
linear_preset  in  LINEAR_WIDTH  linear counter reload value
timer_preset  in  TIMER_WIDTH  period reload value
length_select  in  5  length table index
mode  in  1  0 = triangle, 1 = sawtooth
reg_event  in  1  one-cycle strobe on write to length/period-high register
wave_data  out  DATA_WIDTH  registered sample to mixer
length_active  out  1  high when length counter != 0 (status read)

Behaviour:
- Reset (async, reset_n low) clears timer, sequencer, linear counter, reload flag, length counter and wave_data to 0. length_active is 0.
- All other logic is synchronous on the rising edge of clk. Strobes are one cycle wide and may coincide.
- Timer, on enable_cpu only:
  - if timer == 0: reload timer_preset and raise seq_tick for that cycle
  - else: decrement by 1
  - Tick period is (timer_preset+1) enable_cpu pulses.
- Sequencer advances by 1 (wrapping modulo 2^(DATA_WIDTH+1)) when seq_tick && linear != 0 && length != 0. Otherwise it holds its value, never resets.
- Linear counter, on enable_quarter:
  - if reload flag set: counter <= linear_preset
  - else if nonzero: decrement by 1
  - then, if control == 0: clear reload flag
  - reg_event sets the reload flag and wins over a same-cycle clear.
- Length counter, priority high to low:
  1. channel_enable == 0 -> 0
  2. reg_event -> table[length_select]
  3. enable_half && control == 0 && nonzero -> decrement by 1
  - A load wins over a same-cycle decrement.
- Length table (decimal), index 0..31: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
  - Counter width is 8 bits.
- wave_data is registered from the current sequencer value s, so latency is 1 clk after a sequencer change. Let H = 2^DATA_WIDTH.
  - mode 0 (triangle): s < H -> MAX - s; else s - H. Gives F..0,0..F for DATA_WIDTH=4.
  - mode 1 (sawtooth): s >> 1, i.e. 0..MAX with each value held for 2 steps.
  - Ultrasonic mute: if timer_preset < ULTRASONIC_MIN, wave_data = 2^(DATA_WIDTH-1), regardless of mode. The sequencer still clocks normally.
  - Mode change takes effect on the next clk with no sequencer disturbance.
- When either counter is 0, the sequencer freezes and wave_data holds its last value. It is not silenced to 0.
- length_active is combinational from the length counter == 0 compare.

Test Plan:
- Reset: assert reset_n=0 mid-sequence -> wave_data=0, length_active=0 immediately. After release, first clk -> wave_data=F (mode 0, s=0).
- Triangle period: timer_preset=3, linear_preset=127, length_select=1 (254), reg_event, enable_cpu every clk, one enable_quarter -> sequencer steps every 4 clks. wave_data runs F,E,…,0,0,1,…,F and repeats every 128 clks.
- Linear/control: control=0, linear_preset=2, reg_event, 3 enable_quarter pulses -> counter 2,1,0. Sequencer then freezes with wave_data held. With control=1 the counter reloads to 2 on every quarter strobe.
- Length: length_select=3 (2), control=0, reg_event, 2 enable_half -> length_active 1,1,0. channel_enable=0 forces 0 at once; reg_event with channel_enable=0 -> stays 0. Coincident reg_event+enable_half -> loaded value, no decrement.
- Sawtooth mode: mode=1, timer_preset=0 not applicable (muted). With timer_preset=2 -> wave_data 0,0,1,1,…,F,F, then wraps to 0.
- Ultrasonic: timer_preset=1 -> wave_data=8 constant while sequencer advances. Set timer_preset=2 -> normal waveform resumes from current s.

Source files
------------

// File: rtl/triangle_gen_if.sv
// triangle_gen_if
//   Bundles the register-file / frame-sequencer side of a triangle_gen voice.
//   master: register file + frame sequencer (drives strobes and config,
//           reads back the sample and length status)
//   slave : triangle_gen itself
// Signals:
//   enable_cpu      timer tick strobe
//   enable_quarter  quarter-frame strobe, clocks the linear counter
//   enable_half     half-frame strobe, clocks the length counter
//   channel_enable  $4015 channel bit, low forces the length counter to 0
//   control         length-halt / linear-control flag
//   linear_preset   linear counter reload value
//   timer_preset    period reload value
//   length_select   length table index
//   mode            0 = triangle, 1 = sawtooth
//   reg_event       strobe on write to the length/period-high register
//   wave_data       registered sample to the mixer
//   length_active   high while the length counter is nonzero
interface triangle_gen_if #(
  parameter int TIMER_WIDTH  = 11,
  parameter int DATA_WIDTH   = 4,
  parameter int LINEAR_WIDTH = 7
);
  logic                    enable_cpu;
  logic                    enable_quarter;
  logic                    enable_half;
  logic                    channel_enable;
  logic                    control;
  logic [LINEAR_WIDTH-1:0] linear_preset;
  logic [TIMER_WIDTH-1:0]  timer_preset;
  logic [4:0]              length_select;
  logic                    mode;
  logic                    reg_event;
  logic [DATA_WIDTH-1:0]   wave_data;
  logic                    length_active;

  modport master (
    output enable_cpu, enable_quarter, enable_half, channel_enable, control,
           linear_preset, timer_preset, length_select, mode, reg_event,
    input  wave_data, length_active
  );

  modport slave (
    input  enable_cpu, enable_quarter, enable_half, channel_enable, control,
           linear_preset, timer_preset, length_select, mode, reg_event,
    output wave_data, length_active
  );
endinterface

// File: rtl/triangle_gen.sv
// triangle_gen
//   One wave voice of the APU-style triangle channel: period timer, step
//   sequencer, linear counter, length counter and sample shaper
//   (triangle / sawtooth, with ultrasonic mute).
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      triangle_gen_if.slave - strobes, configuration, sample and
//            length status
module triangle_gen #(
  parameter int TIMER_WIDTH    = 11,
  parameter int DATA_WIDTH     = 4,
  parameter int LINEAR_WIDTH   = 7,
  parameter int ULTRASONIC_MIN = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  triangle_gen_if.slave  bus
);

  localparam int SEQ_WIDTH = DATA_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] WAVE_MID = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [TIMER_WIDTH-1:0]  timer_q,  timer_d;
  logic [SEQ_WIDTH-1:0]    seq_q,    seq_d;
  logic [LINEAR_WIDTH-1:0] linear_q, linear_d;
  logic                    reload_q, reload_d;
  logic [7:0]              length_q, length_d;
  logic [DATA_WIDTH-1:0]   wave_q,   wave_d;

  logic seq_tick;
  logic mute;

  function automatic logic [7:0] length_lookup(input logic [4:0] idx);
    logic [7:0] val;
    case (idx)
      5'd0:  val = 8'd10;
      5'd1:  val = 8'd254;
      5'd2:  val = 8'd20;
      5'd3:  val = 8'd2;
      5'd4:  val = 8'd40;
      5'd5:  val = 8'd4;
      5'd6:  val = 8'd80;
      5'd7:  val = 8'd6;
      5'd8:  val = 8'd160;
      5'd9:  val = 8'd8;
      5'd10: val = 8'd60;
      5'd11: val = 8'd10;
      5'd12: val = 8'd14;
      5'd13: val = 8'd12;
      5'd14: val = 8'd26;
      5'd15: val = 8'd14;
      5'd16: val = 8'd12;
      5'd17: val = 8'd16;
      5'd18: val = 8'd24;
      5'd19: val = 8'd18;
      5'd20: val = 8'd48;
      5'd21: val = 8'd20;
      5'd22: val = 8'd96;
      5'd23: val = 8'd22;
      5'd24: val = 8'd192;
      5'd25: val = 8'd24;
      5'd26: val = 8'd72;
      5'd27: val = 8'd26;
      5'd28: val = 8'd16;
      5'd29: val = 8'd28;
      5'd30: val = 8'd32;
      default: val = 8'd30;
    endcase
    return val;
  endfunction

  // Timer: counts down on CPU ticks; reaching zero reloads and emits a
  // sequencer tick, so the tick period is timer_preset+1 CPU ticks.
  always_comb begin
    timer_d  = timer_q;
    seq_tick = 1'b0;
    if (bus.enable_cpu) begin
      if (timer_q == '0) begin
        timer_d  = bus.timer_preset;
        seq_tick = 1'b1;
      end else begin
        timer_d = timer_q - TIMER_WIDTH'(1);
      end
    end
  end

  // Sequencer only moves while both gating counters are nonzero; it is never
  // reset by the counters, so the waveform resumes where it froze.
  always_comb begin
    seq_d = seq_q;
    if (seq_tick && (linear_q != '0) && (length_q != 8'd0)) begin
      seq_d = seq_q + SEQ_WIDTH'(1);
    end
  end

  // Linear counter and reload flag. A register write sets the flag even if
  // the same quarter-frame would otherwise clear it.
  always_comb begin
    linear_d = linear_q;
    reload_d = reload_q;
    if (bus.enable_quarter) begin
      if (reload_q) begin
        linear_d = bus.linear_preset;
      end else if (linear_q != '0) begin
        linear_d = linear_q - LINEAR_WIDTH'(1);
      end
      if (!bus.control) begin
        reload_d = 1'b0;
      end
    end
    if (bus.reg_event) begin
      reload_d = 1'b1;
    end
  end

  // Length counter: channel disable beats load, load beats decrement.
  always_comb begin
    length_d = length_q;
    if (!bus.channel_enable) begin
      length_d = 8'd0;
    end else if (bus.reg_event) begin
      length_d = length_lookup(bus.length_select);
    end else if (bus.enable_half && !bus.control && (length_q != 8'd0)) begin
      length_d = length_q - 8'd1;
    end
  end

  // Sample shaper. Triangle: first half of the sequence counts down from MAX
  // (bitwise inverse of the low bits), second half counts up. Sawtooth drops
  // the sequencer LSB so each level lasts two steps.
  assign mute = (bus.timer_preset < TIMER_WIDTH'(ULTRASONIC_MIN));

  always_comb begin
    wave_d = wave_q;
    if (mute) begin
      wave_d = WAVE_MID;
    end else if (bus.mode) begin
      wave_d = seq_q[SEQ_WIDTH-1:1];
    end else if (!seq_q[DATA_WIDTH]) begin
      wave_d = ~seq_q[DATA_WIDTH-1:0];
    end else begin
      wave_d = seq_q[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q  <= '0;
      seq_q    <= '0;
      linear_q <= '0;
      reload_q <= 1'b0;
      length_q <= 8'd0;
      wave_q   <= '0;
    end else begin
      timer_q  <= timer_d;
      seq_q    <= seq_d;
      linear_q <= linear_d;
      reload_q <= reload_d;
      length_q <= length_d;
      wave_q   <= wave_d;
    end
  end

  assign bus.wave_data     = wave_q;
  assign bus.length_active = (length_q != 8'd0);

endmodule

// File: tb/tb_triangle_gen.sv
// tb_triangle_gen
//   Self-checking bench for triangle_gen. Each cycle the stimulus is driven,
//   a behavioural model computes the expected post-edge outputs and pushes
//   them to a scoreboard queue; after the clock edge the entry is popped and
//   compared against the DUT.
module tb_triangle_gen;

  localparam int TW       = 11;
  localparam int DW       = 4;
  localparam int LW       = 7;
  localparam int H        = 16;
  localparam int WAVE_MAX = 15;
  localparam int STEPS    = 32;
  localparam int WAVE_MID = 8;
  localparam int US_MIN   = 2;

  localparam int LEN_TABLE [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60,
                                    10, 14, 12, 26, 14, 12, 16, 24, 18, 48, 20,
                                    96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

  typedef struct {
    int wave;
    int active;
  } exp_t;

  logic clk;
  logic reset_n;

  triangle_gen_if #(.TIMER_WIDTH(TW), .DATA_WIDTH(DW), .LINEAR_WIDTH(LW)) bus ();

  triangle_gen #(
    .TIMER_WIDTH(TW), .DATA_WIDTH(DW), .LINEAR_WIDTH(LW), .ULTRASONIC_MIN(US_MIN)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus variables copied onto the interface each cycle.
  bit in_cpu, in_quarter, in_half, in_channel_enable, in_control, in_mode, in_reg_event;
  int in_linear_preset, in_timer_preset, in_length_select;

  // Reference model state.
  int m_timer, m_seq, m_lin, m_len;
  bit m_reload;

  exp_t exp_q[$];
  int n_checks;
  int n_fail;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_timer  = 0;
    m_seq    = 0;
    m_lin    = 0;
    m_len    = 0;
    m_reload = 1'b0;
    exp_q.delete();
  endtask

  // Called away from the clock edge: drives inputs, steps the model, waits
  // one edge, then pops and compares. Strobes are cleared afterwards.
  task automatic applyStimulus();
    exp_t e;
    exp_t got;
    bit tick;
    int nt, ns, nl, nlen, nw;
    bit nr;

    bus.enable_cpu     = in_cpu;
    bus.enable_quarter = in_quarter;
    bus.enable_half    = in_half;
    bus.channel_enable = in_channel_enable;
    bus.control        = in_control;
    bus.linear_preset  = LW'(in_linear_preset);
    bus.timer_preset   = TW'(in_timer_preset);
    bus.length_select  = 5'(in_length_select);
    bus.mode           = in_mode;
    bus.reg_event      = in_reg_event;

    tick = in_cpu && (m_timer == 0);
    nt = m_timer;
    if (in_cpu) nt = (m_timer == 0) ? in_timer_preset : m_timer - 1;

    ns = m_seq;
    if (tick && m_lin != 0 && m_len != 0) ns = (m_seq + 1) % STEPS;

    nl = m_lin;
    nr = m_reload;
    if (in_quarter) begin
      if (m_reload) nl = in_linear_preset;
      else if (m_lin > 0) nl = m_lin - 1;
      if (!in_control) nr = 1'b0;
    end
    if (in_reg_event) nr = 1'b1;

    nlen = m_len;
    if (!in_channel_enable) nlen = 0;
    else if (in_reg_event) nlen = LEN_TABLE[in_length_select];
    else if (in_half && !in_control && m_len > 0) nlen = m_len - 1;

    if (in_timer_preset < US_MIN) nw = WAVE_MID;
    else if (in_mode) nw = m_seq / 2;
    else if (m_seq < H) nw = WAVE_MAX - m_seq;
    else nw = m_seq - H;

    m_timer  = nt;
    m_seq    = ns;
    m_lin    = nl;
    m_reload = nr;
    m_len    = nlen;
    e.wave   = nw;
    e.active = (nlen != 0) ? 1 : 0;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL sb_empty: got empty queue, expected an entry");
    end else begin
      got = exp_q.pop_front();
      checkOutput("wave", int'(bus.wave_data), got.wave);
      checkOutput("active", int'(bus.length_active), got.active);
    end

    in_cpu       = 1'b0;
    in_quarter   = 1'b0;
    in_half      = 1'b0;
    in_reg_event = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    checkOutput("rst_wave", int'(bus.wave_data), 0);
    checkOutput("rst_active", int'(bus.length_active), 0);
    model_reset();
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run_cycles(input int n, input bit cpu);
    for (int i = 0; i < n; i++) begin
      in_cpu = cpu;
      applyStimulus();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b1;
    in_cpu = 0; in_quarter = 0; in_half = 0; in_reg_event = 0;
    in_channel_enable = 1; in_control = 0; in_mode = 0;
    in_linear_preset = 127; in_timer_preset = 3; in_length_select = 1;
    bus.enable_cpu = 0; bus.enable_quarter = 0; bus.enable_half = 0;
    bus.channel_enable = 1; bus.control = 0; bus.mode = 0; bus.reg_event = 0;
    bus.linear_preset = '0; bus.timer_preset = '0; bus.length_select = '0;

    #1;
    do_reset();

    // First clock after reset: s=0 in triangle mode gives MAX.
    applyStimulus();
    checkOutput("post_reset_wave", int'(bus.wave_data), 15);

    // Triangle period: load length and linear, then tick every clock.
    in_reg_event = 1; applyStimulus();
    in_quarter = 1;   applyStimulus();
    run_cycles(140, 1'b1);

    // Linear counter with control=0: 2,1,0 then freeze.
    in_linear_preset = 2; in_control = 0;
    in_reg_event = 1; applyStimulus();
    for (int i = 0; i < 3; i++) begin
      in_quarter = 1; in_cpu = 1; applyStimulus();
      run_cycles(5, 1'b1);
    end
    run_cycles(20, 1'b1);
    // Control=1 keeps the reload flag, so each quarter reloads to 2.
    in_control = 1;
    in_reg_event = 1; applyStimulus();
    for (int i = 0; i < 6; i++) begin
      in_quarter = 1; in_cpu = 1; applyStimulus();
      run_cycles(4, 1'b1);
    end

    // Length counter.
    in_control = 0; in_length_select = 3;
    in_reg_event = 1; applyStimulus();
    checkOutput("len_load", int'(bus.length_active), 1);
    in_half = 1; applyStimulus();
    checkOutput("len_dec1", int'(bus.length_active), 1);
    in_half = 1; applyStimulus();
    checkOutput("len_dec2", int'(bus.length_active), 0);
    in_reg_event = 1; applyStimulus();
    in_channel_enable = 0; applyStimulus();
    checkOutput("len_ch_off", int'(bus.length_active), 0);
    in_reg_event = 1; applyStimulus();
    checkOutput("len_ch_off_load", int'(bus.length_active), 0);
    in_channel_enable = 1;
    in_reg_event = 1; in_half = 1; applyStimulus();
    checkOutput("len_load_vs_dec", int'(bus.length_active), 1);
    in_half = 1; applyStimulus();
    checkOutput("len_after_coinc", int'(bus.length_active), 1);
    in_half = 1; applyStimulus();
    checkOutput("len_coinc_empty", int'(bus.length_active), 0);

    // Length table sweep: half-frames until the counter empties.
    for (int idx = 0; idx < 32; idx++) begin
      int count;
      in_length_select = idx;
      in_reg_event = 1; applyStimulus();
      count = 0;
      while (bus.length_active && count < 300) begin
        in_half = 1; applyStimulus();
        count++;
      end
      checkOutput($sformatf("len_tbl_%0d", idx), count, LEN_TABLE[idx]);
    end

    // Sawtooth with counters held (control=1).
    in_control = 1; in_linear_preset = 127; in_length_select = 1;
    in_reg_event = 1; applyStimulus();
    in_quarter = 1;   applyStimulus();
    in_mode = 1; in_timer_preset = 2;
    run_cycles(200, 1'b1);

    // Ultrasonic mute holds the midpoint while the sequencer keeps running.
    in_timer_preset = 1;
    for (int i = 0; i < 20; i++) begin
      in_cpu = 1; applyStimulus();
      checkOutput("ultrasonic", int'(bus.wave_data), 8);
    end
    in_mode = 0; in_timer_preset = 2;
    run_cycles(30, 1'b1);

    // Random mix of strobes, presets and mode.
    for (int i = 0; i < 400; i++) begin
      in_cpu            = ($urandom_range(0, 3) != 0);
      in_quarter        = ($urandom_range(0, 15) == 0);
      in_half           = ($urandom_range(0, 15) == 0);
      in_reg_event      = ($urandom_range(0, 31) == 0);
      in_channel_enable = ($urandom_range(0, 31) != 0);
      in_control        = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 63) == 0) in_mode = ~in_mode;
      if ($urandom_range(0, 31) == 0) in_timer_preset = $urandom_range(0, 5);
      in_linear_preset  = $urandom_range(0, 10);
      in_length_select  = $urandom_range(0, 31);
      applyStimulus();
    end

    // Mid-sequence reset, then first edge back in triangle mode.
    do_reset();
    in_mode = 0; in_timer_preset = 3;
    applyStimulus();
    checkOutput("post_reset2_wave", int'(bus.wave_data), 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
